// File: rtl/axi_mem_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port (AR/R) of axi_memory among NUM_REQ requesters.
// Holds one read in flight and routes its single-beat response back. A watchdog turns a missing response into SLVERR.
module axi_mem_rd_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            M_ARVALID,
  output logic [NUM_REQ-1:0]            M_ARREADY,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] M_ARADDR,
  output logic [NUM_REQ-1:0]            M_RVALID,
  input  logic [NUM_REQ-1:0]            M_RREADY,
  output logic [DATA_WIDTH-1:0]         M_RDATA,
  output logic [1:0]                    M_RRESP,
  output logic                          S_ARVALID,
  input  logic                          S_ARREADY,
  output logic [ADDR_WIDTH-1:0]         S_ARADDR,
  input  logic                          S_RVALID,
  output logic                          S_RREADY,
  input  logic [DATA_WIDTH-1:0]         S_RDATA,
  input  logic [1:0]                    S_RRESP,
  output logic                          R_EN
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, gnt_nxt;
  logic [GW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [GW-1:0]   arb_idx;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   gnt_inc;

  // Round-robin pick: the lowest offset from ptr with a valid request wins.
  always_comb begin
    arb_idx = '0;
    cand    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = GW'((int'(ptr) + k) % int'(NUM_REQ));
      if (M_ARVALID[cand]) begin
        arb_idx = cand;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and channel steering; all port steering follows the granted requester.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_inc   = (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + GW'(1);
    M_ARREADY = '0;
    M_RVALID  = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    S_ARVALID = 1'b0;
    S_ARADDR  = '0;
    S_RREADY  = 1'b0;
    R_EN      = 1'b0;
    case (state)
      IDLE: begin
        S_RREADY = 1'b1;
        if (|M_ARVALID) begin
          gnt_nxt   = arb_idx;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        S_ARVALID      = M_ARVALID[gnt];
        S_ARADDR       = M_ARADDR[int'(gnt)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
        M_ARREADY[gnt] = S_ARREADY;
        R_EN           = 1'b1;
        if (M_ARVALID[gnt] && S_ARREADY) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        M_RVALID[gnt] = S_RVALID;
        S_RREADY      = M_RREADY[gnt];
        M_RDATA       = S_RDATA;
        M_RRESP       = S_RRESP;
        R_EN          = 1'b1;
        if (S_RVALID && M_RREADY[gnt]) begin
          ptr_nxt   = gnt_inc;
          state_nxt = IDLE;
        end else if (!S_RVALID && (TIMEOUT_CYC != 0)) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state_nxt = ERR;
          end
        end
      end
      ERR: begin
        M_RVALID[gnt] = 1'b1;
        M_RRESP       = RESP_SLVERR;
        if (M_RREADY[gnt]) begin
          ptr_nxt   = gnt_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
